deserializador_32: RTL
======================

DESERIALIZADOR_32 -- requirements
Module: deserializador_32

Interface
REQ-001 The block SHALL expose: CLK  input  1  single clock, all state on rising edge.
REQ-002 The block SHALL expose: RESET  input  1  asynchronous, active-high reset.
REQ-003 The block SHALL expose: ENB  input  1  sample enable; S_IN sampled only when 1.
REQ-004 The block SHALL expose: INICIO  input  1  frame start strobe, one cycle before first data bit.
REQ-005 The block SHALL expose: DIR  input  1  bit order, 1 = MSB first, 0 = LSB first; captured at frame start.
REQ-006 The block SHALL expose: S_IN  input  1  serial data, driven by the shift register's S_OUT32.
REQ-007 The block SHALL expose: LEER  input  1  consumer acknowledge of held word.
REQ-008 The block SHALL expose: Q  output  32  last complete word.
REQ-009 The block SHALL expose: VALIDO  output  1  level, word in Q unread.
REQ-010 The block SHALL expose: OCUPADO  output  1  frame reception in progress.
REQ-011 The block SHALL expose: CONTEO  output  6  bits received in current frame, 0..32.
REQ-012 The block SHALL expose: SOBRECARGA  output  1  sticky overrun flag.
REQ-013 The block SHALL expose: ERR_PARIDAD  output  1  parity error of word in Q.

Function
REQ-014 FSM states SHALL be IDLE, RECIBE, PARIDAD (only with PARIDAD_EN), LLENO.
REQ-015 IDLE: INICIO=1 and ENB=1 -> RECIBE next edge; CONTEO<=0; DIR latched; S_IN in that cycle not sampled.
REQ-016 RECIBE: each edge with ENB=1 samples S_IN and increments CONTEO; ENB=0 freezes shift data and CONTEO.
REQ-017 DIR=1 SHALL shift left, new bit into bit 0 (first bit ends at Q[31]); DIR=0 SHALL shift right, new bit into bit 31 (first bit ends at Q[0]).
REQ-018 Q SHALL update only on frame completion; partial frames never visible on Q.
REQ-019 On the edge sampling bit 32 (no PARIDAD_EN): Q<=word, VALIDO<=1, state -> LLENO; zero added latency.
REQ-020 LLENO: LEER=1 -> IDLE next edge, VALIDO<=0, Q held unchanged.
REQ-021 INICIO during RECIBE or PARIDAD SHALL be ignored.
REQ-022 INICIO=1, ENB=1 in LLENO with LEER=0: SOBRECARGA<=1, held word and state unchanged.
REQ-023 INICIO=1, ENB=1 and LEER=1 same cycle in LLENO: acknowledge and new frame start both accepted, -> RECIBE, VALIDO<=0, no overrun.
REQ-024 OCUPADO SHALL equal 1 exactly in RECIBE and PARIDAD.
REQ-025 SOBRECARGA SHALL clear only by RESET.

Reset
REQ-026 RESET=1 SHALL immediately force state IDLE and Q, VALIDO, OCUPADO, CONTEO, SOBRECARGA, ERR_PARIDAD and internal shift data to 0, independent of CLK.
REQ-027 Reset mid-frame SHALL discard partial data; first edge after release with INICIO=1, ENB=1 starts a fresh frame.

Configuration
REQ-028 Macro DESERIALIZADOR_PARIDAD_EN defined: after bit 32, state PARIDAD samples one extra bit (ENB-gated); on that edge Q and VALIDO load, ERR_PARIDAD<= (XOR of 32 data bits XOR parity bit), even parity; ERR_PARIDAD held until next word load or reset.
REQ-029 Macro undefined: no PARIDAD state, no 33rd bit, ERR_PARIDAD tied 0.

Verification
REQ-030 Reset, INICIO, DIR=1, 32 bits of 0xA5A5_0F0F MSB first, ENB=1 -> Q=0xA5A5_0F0F, VALIDO=1 on 32nd sample edge, CONTEO=32.
REQ-031 Same stream with DIR=0 (bit 0 first) -> Q=0xA5A5_0F0F; LEER pulse -> VALIDO=0 next edge, Q unchanged.
REQ-032 Frame of 0xFFFF_FFFF with ENB=0 for 5 cycles after bit 10 -> CONTEO holds 10 for 5 cycles; completion 5 cycles late, Q=0xFFFF_FFFF.
REQ-033 VALIDO=1, INICIO without LEER -> SOBRECARGA=1, Q retained; INICIO with LEER -> SOBRECARGA stays 0, OCUPADO=1.
REQ-034 RESET after bit 20 of frame -> all outputs 0 asynchronously; next full frame 0x1234_5678 received correctly.
REQ-035 With DESERIALIZADOR_PARIDAD_EN: word 0x0000_0001 plus parity 0 -> ERR_PARIDAD=1; parity 1 -> ERR_PARIDAD=0.

Source files
------------

// File: rtl/deserializador_32_if.sv
// Bus bundle for deserializador_32.
// Handshake: the producer strobes INICIO with ENB one cycle before the first
// data bit. It then presents S_IN, and each bit is taken on an edge where ENB=1.
// The word in Q is valid while VALIDO=1 and stays held until the consumer
// pulses LEER, which clears VALIDO on the next edge.
interface deserializador_32_if;
  logic        ENB;
  logic        INICIO;
  logic        DIR;
  logic        S_IN;
  logic        LEER;
  logic [31:0] Q;
  logic        VALIDO;
  logic        OCUPADO;
  logic [5:0]  CONTEO;
  logic        SOBRECARGA;
  logic        ERR_PARIDAD;
  logic [1:0]  ESTADO_DBG;   // FSM state: 0 IDLE, 1 RECIBE, 2 PARIDAD, 3 LLENO

  modport master (
    output ENB, INICIO, DIR, S_IN, LEER,
    input  Q, VALIDO, OCUPADO, CONTEO, SOBRECARGA, ERR_PARIDAD, ESTADO_DBG
  );

  modport slave (
    input  ENB, INICIO, DIR, S_IN, LEER,
    output Q, VALIDO, OCUPADO, CONTEO, SOBRECARGA, ERR_PARIDAD, ESTADO_DBG
  );
endinterface

// File: rtl/deserializador_32.sv
// 32-bit serial-to-parallel receiver with a held output word and a sticky overrun flag.
// Optional macro DESERIALIZADOR_PARIDAD_EN adds an even-parity bit after the 32 data bits.
module deserializador_32 (
  input  logic                CLK,
  input  logic                RESET,
  deserializador_32_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECIBE  = 2'd1,
`ifdef DESERIALIZADOR_PARIDAD_EN
    PARIDAD = 2'd2,
`endif
    LLENO   = 2'd3
  } estado_t;

  estado_t     r_estado;
  estado_t     w_estado_sig;
  logic [31:0] r_shift;
  logic [31:0] r_q;
  logic [5:0]  r_conteo;
  logic        r_dir;
  logic        r_valido;
  logic        r_sobrecarga;
  logic        w_inicio;
  logic        w_ultimo;
  logic [31:0] w_shift_sig;

  assign w_inicio = bus.INICIO & bus.ENB;
  assign w_ultimo = (r_conteo == 6'd31);
  // MSB-first shifts left so the first bit ends up at bit 31. LSB-first shifts right
  // so the first bit ends up at bit 0.
  assign w_shift_sig = r_dir ? {r_shift[30:0], bus.S_IN} : {bus.S_IN, r_shift[31:1]};

  // Next-state logic
  always_comb begin
    w_estado_sig = r_estado;
    case (r_estado)
      IDLE:   if (w_inicio) w_estado_sig = RECIBE;
      RECIBE: if (bus.ENB && w_ultimo) begin
`ifdef DESERIALIZADOR_PARIDAD_EN
        w_estado_sig = PARIDAD;
`else
        w_estado_sig = LLENO;
`endif
      end
`ifdef DESERIALIZADOR_PARIDAD_EN
      PARIDAD: if (bus.ENB) w_estado_sig = LLENO;
`endif
      LLENO:  if (bus.LEER) w_estado_sig = w_inicio ? RECIBE : IDLE;
      default: w_estado_sig = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_estado <= IDLE;
    else       r_estado <= w_estado_sig;
  end

`ifdef DESERIALIZADOR_PARIDAD_EN
  logic r_err;
`endif

  // Datapath: shift register, bit count, held word and flags
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_shift      <= '0;
      r_q          <= '0;
      r_conteo     <= '0;
      r_dir        <= 1'b0;
      r_valido     <= 1'b0;
      r_sobrecarga <= 1'b0;
`ifdef DESERIALIZADOR_PARIDAD_EN
      r_err        <= 1'b0;
`endif
    end else begin
      case (r_estado)
        IDLE: if (w_inicio) begin
          r_conteo <= '0;
          r_dir    <= bus.DIR;
          r_shift  <= '0;
        end
        RECIBE: if (bus.ENB) begin
          r_shift  <= w_shift_sig;
          r_conteo <= r_conteo + 6'd1;
`ifndef DESERIALIZADOR_PARIDAD_EN
          if (w_ultimo) begin
            r_q      <= w_shift_sig;
            r_valido <= 1'b1;
          end
`endif
        end
`ifdef DESERIALIZADOR_PARIDAD_EN
        PARIDAD: if (bus.ENB) begin
          r_q      <= r_shift;
          r_valido <= 1'b1;
          r_err    <= (^r_shift) ^ bus.S_IN;
        end
`endif
        LLENO: begin
          if (bus.LEER) begin
            r_valido <= 1'b0;
            if (w_inicio) begin
              r_conteo <= '0;
              r_dir    <= bus.DIR;
              r_shift  <= '0;
            end
          end else if (w_inicio) begin
            // A new frame while the held word is unread is refused and flagged.
            r_sobrecarga <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Q          = r_q;
  assign bus.VALIDO     = r_valido;
  assign bus.CONTEO     = r_conteo;
  assign bus.SOBRECARGA = r_sobrecarga;
  assign bus.ESTADO_DBG = r_estado;
`ifdef DESERIALIZADOR_PARIDAD_EN
  assign bus.OCUPADO     = (r_estado == RECIBE) || (r_estado == PARIDAD);
  assign bus.ERR_PARIDAD = r_err;
`else
  assign bus.OCUPADO     = (r_estado == RECIBE);
  assign bus.ERR_PARIDAD = 1'b0;
`endif

endmodule
